mips_boot_sequencer: RTL and testbench

Bring-up controller for `mips_cpu_harvard`: holds the CPU in reset, loads a program from a byte-wide host stream into instruction memory as big-endian words starting at the reset vector, then releases the CPU. It gates the CPU clock enable, watches `active` for the halt, and captures `register_v0` as the result. It sits between the host or bench loader, the instruction memory write port, and the CPU's `reset`, `clk_enable`, `active` and `register_v0` pins.

---
 rtl/mips_boot_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_mips_boot_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_boot_sequencer.sv
// mips_boot_sequencer: loads a big-endian program into instruction memory from a byte stream,
// then runs the CPU until it halts or times out. Rev 1.0
`default_nettype none

module mips_boot_sequencer #(
  parameter int          ADDR_W         = 10,
  parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_write,
  output logic [31:0]       imem_address,
  output logic [31:0]       imem_writedata,
  output logic              cpu_reset,
  output logic              cpu_clk_enable,
  input  logic              cpu_active,
  input  logic [31:0]       cpu_register_v0,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       result
);

  localparam int                CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W:0]   MAX_WORDS  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_CYCLE = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_RESET_CPU = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [ADDR_W:0]  word_idx_q, word_idx_d;
  logic [ADDR_W:0]  words_q, words_d;
  logic [23:0]      shift_q, shift_d;
  logic             rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             imem_write_q, imem_write_d;
  logic [31:0]      imem_address_q, imem_address_d;
  logic [31:0]      imem_writedata_q, imem_writedata_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      result_q, result_d;
  logic             byte_ready_q, cpu_reset_q, cpu_clk_enable_q, busy_q, done_q;

  logic [ADDR_W:0]  w_words;
  logic [ADDR_W:0]  w_next_word;

  assign w_words     = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
  assign w_next_word = word_idx_q + 1'b1;

  always_comb begin
    state_d          = state_q;
    byte_idx_d       = byte_idx_q;
    word_idx_d       = word_idx_q;
    words_d          = words_q;
    shift_d          = shift_q;
    rst_cnt_d        = rst_cnt_q;
    cyc_d            = cyc_q;
    imem_write_d     = 1'b0;
    imem_address_d   = imem_address_q;
    imem_writedata_d = imem_writedata_q;
    timeout_d        = timeout_q;
    result_d         = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          words_d    = w_words;
          byte_idx_d = 2'd0;
          word_idx_d = '0;
          rst_cnt_d  = 1'b0;
          timeout_d  = 1'b0;
          state_d    = (w_words != '0) ? S_LOAD : S_RESET_CPU;
        end
      end
      S_LOAD: begin
        if (byte_valid && byte_ready_q) begin
          byte_idx_d = byte_idx_q + 2'd1;
          shift_d    = {shift_q[15:0], byte_data};
          if (byte_idx_q == 2'd3) begin
            imem_writedata_d = {shift_q, byte_data};
            imem_address_d   = RESET_VECTOR + (32'(word_idx_q) << 2);
            imem_write_d     = 1'b1;
            word_idx_d       = w_next_word;
            if (w_next_word == words_q) begin
              rst_cnt_d = 1'b0;
              state_d   = S_RESET_CPU;
            end
          end
        end
      end
      S_RESET_CPU: begin
        if (rst_cnt_q) begin
          cyc_d   = '0;
          state_d = S_RUN;
        end else begin
          rst_cnt_d = 1'b1;
        end
      end
      S_RUN: begin
        // A halt seen on the very first cycle is stale CPU state, hence n >= 1.
        if ((cyc_q != '0) && !cpu_active) begin
          result_d  = cpu_register_v0;
          timeout_d = 1'b0;
          state_d   = S_DONE;
        end else if (cyc_q == LAST_CYCLE) begin
          result_d  = cpu_register_v0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      byte_idx_q       <= 2'd0;
      word_idx_q       <= '0;
      words_q          <= '0;
      shift_q          <= '0;
      rst_cnt_q        <= 1'b0;
      cyc_q            <= '0;
      imem_write_q     <= 1'b0;
      imem_address_q   <= RESET_VECTOR;
      imem_writedata_q <= '0;
      timeout_q        <= 1'b0;
      result_q         <= '0;
      byte_ready_q     <= 1'b0;
      cpu_reset_q      <= 1'b1;
      cpu_clk_enable_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      byte_idx_q       <= byte_idx_d;
      word_idx_q       <= word_idx_d;
      words_q          <= words_d;
      shift_q          <= shift_d;
      rst_cnt_q        <= rst_cnt_d;
      cyc_q            <= cyc_d;
      imem_write_q     <= imem_write_d;
      imem_address_q   <= imem_address_d;
      imem_writedata_q <= imem_writedata_d;
      timeout_q        <= timeout_d;
      result_q         <= result_d;
      // Per-state outputs are registered from the next state so they align with it.
      byte_ready_q     <= (state_d == S_LOAD);
      cpu_reset_q      <= (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_RESET_CPU);
      cpu_clk_enable_q <= (state_d == S_RESET_CPU) || (state_d == S_RUN);
      busy_q           <= (state_d == S_LOAD) || (state_d == S_RESET_CPU) || (state_d == S_RUN);
      done_q           <= (state_d == S_DONE);
    end
  end

  assign byte_ready     = byte_ready_q;
  assign imem_write     = imem_write_q;
  assign imem_address   = imem_address_q;
  assign imem_writedata = imem_writedata_q;
  assign cpu_reset      = cpu_reset_q;
  assign cpu_clk_enable = cpu_clk_enable_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign result         = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_boot_sequencer.sv
// tb_mips_boot_sequencer: scoreboard bench; expected writes and run outcomes are queued by the
// stimulus thread and consumed by an independent monitor.
`default_nettype none

module tb_mips_boot_sequencer;
  localparam int          AW = 3;
  localparam int          TO = 16;
  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [AW:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, imem_write;
  logic [31:0] imem_address, imem_writedata;
  logic        cpu_reset, cpu_clk_enable, cpu_active;
  logic [31:0] cpu_register_v0;
  logic        busy, done, timeout;
  logic [31:0] result;

  mips_boot_sequencer #(.ADDR_W(AW), .RESET_VECTOR(RV), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_write(imem_write), .imem_address(imem_address), .imem_writedata(imem_writedata),
    .cpu_reset(cpu_reset), .cpu_clk_enable(cpu_clk_enable), .cpu_active(cpu_active),
    .cpu_register_v0(cpu_register_v0), .busy(busy), .done(done), .timeout(timeout),
    .result(result)
  );

  always #5 clk = ~clk;

  // CPU stand-in: n_tb is the RUN cycle index, rc_tb counts RESET_CPU cycles.
  int n_tb = 0, rc_tb = 0, halt_at = 1000;
  always @(posedge clk) begin
    n_tb  <= (cpu_clk_enable && !cpu_reset) ? n_tb + 1 : 0;
    rc_tb <= !cpu_clk_enable ? 0 : (cpu_reset ? rc_tb + 1 : rc_tb);
  end
  always_comb cpu_active = (n_tb < halt_at);

  logic [31:0] exp_wa[64], exp_wd[64];
  int          wr_head = 0, wr_tail = 0;
  logic        exp_to[16];
  logic [31:0] exp_res[16];
  int          exp_len[16];
  int          dn_head = 0, dn_tail = 0;
  int          req_cnt = 0, req_seen = 0, req_kind = 0;
  int          errors = 0, checks = 0;
  logic        done_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (imem_write === 1'b1) begin
        if (wr_tail == wr_head) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got %h@%h expected no write", imem_writedata, imem_address);
        end else begin
          chk("write_addr", imem_address, exp_wa[wr_tail]);
          chk("write_data", imem_writedata, exp_wd[wr_tail]);
          wr_tail++;
        end
      end
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (dn_tail == dn_head) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          chk("done_timeout", 32'(timeout), 32'(exp_to[dn_tail]));
          chk("done_result", result, exp_res[dn_tail]);
          chk("run_cycles", n_tb, exp_len[dn_tail]);
          chk("reset_cpu_cycles", rc_tb, 2);
          chk("done_busy", 32'(busy), 0);
          dn_tail++;
        end
      end
      done_prev = done;
      if (req_cnt != req_seen) begin
        req_seen = req_cnt;
        case (req_kind)
          1: begin
            chk("rst_byte_ready", 32'(byte_ready), 0);
            chk("rst_imem_write", 32'(imem_write), 0);
            chk("rst_imem_wdata", imem_writedata, 0);
            chk("rst_imem_addr", imem_address, RV);
            chk("rst_cpu_reset", 32'(cpu_reset), 1);
            chk("rst_cpu_clk_en", 32'(cpu_clk_enable), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_timeout", 32'(timeout), 0);
            chk("rst_result", result, 0);
          end
          2: begin
            chk("load_byte_ready", 32'(byte_ready), 1);
            chk("load_busy", 32'(busy), 1);
            chk("load_cpu_reset", 32'(cpu_reset), 1);
            chk("load_clk_en", 32'(cpu_clk_enable), 0);
          end
          3: begin
            chk("writes_left", wr_head - wr_tail, 0);
            chk("dones_left", dn_head - dn_tail, 0);
          end
          4: begin
            chk("zero_byte_ready", 32'(byte_ready), 0);
            chk("zero_busy", 32'(busy), 1);
            chk("zero_cpu_reset", 32'(cpu_reset), 1);
            chk("zero_clk_en", 32'(cpu_clk_enable), 1);
          end
          default: ;
        endcase
      end
    end
  end

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_wa[wr_head] = a; exp_wd[wr_head] = d; wr_head++;
  endtask

  task automatic push_dn(input logic to, input logic [31:0] r, input int len);
    exp_to[dn_head] = to; exp_res[dn_head] = r; exp_len[dn_head] = len; dn_head++;
  endtask

  task automatic request(input int kind);
    #1;
    req_kind = kind;
    req_cnt++;
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW:0] wc, input int kind);
    @(negedge clk);
    start = 1'b1; word_count = wc;
    @(negedge clk);
    start = 1'b0;
    request(kind);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int k;
    if (stall) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    byte_valid = 1'b1; byte_data = b;
    k = 0;
    while (byte_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      $display("FAIL byte_wait: got byte_ready=%b expected 1 within 100 cycles", byte_ready);
      $fatal(1);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      $display("FAIL done_wait: got done=%b expected 1 within 400 cycles", done);
      $fatal(1);
    end
  endtask

  logic [7:0] prog[16] = '{8'h24, 8'h84, 8'hFF, 8'hF5, 8'h28, 8'h82, 8'hFF, 8'hB3,
                           8'h00, 8'h00, 8'h00, 8'h08, 8'h24, 8'h00, 8'h00, 8'h00};
  int         zh[3]    = '{15, 16, 1};
  int         zlen[3]  = '{16, 16, 2};
  logic       zto[3]   = '{1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
    cpu_register_v0 = '0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    request(1);
    reset = 1'b1;

    // Nominal four-word program.
    push_wr(32'hBFC00000, 32'h2484FFF5);
    push_wr(32'hBFC00004, 32'h2882FFB3);
    push_wr(32'hBFC00008, 32'h00000008);
    push_wr(32'hBFC0000C, 32'h24000000);
    halt_at = 3; cpu_register_v0 = 32'h0; push_dn(1'b0, 32'h0, 4);
    do_start(4, 2);
    for (int i = 0; i < 16; i++) send_byte(prog[i], 1'b0);
    wait_done();

    // Same data with random host stalls.
    push_wr(32'hBFC00000, 32'h2484FFF5);
    push_wr(32'hBFC00004, 32'h2882FFB3);
    halt_at = 0; cpu_register_v0 = 32'h12345678; push_dn(1'b0, 32'h12345678, 2);
    do_start(2, 2);
    for (int i = 0; i < 8; i++) send_byte(prog[i], 1'b1);
    wait_done();

    // Timeout with a start pulse during RUN that must be ignored.
    push_wr(32'hBFC00000, 32'h01020304);
    halt_at = 1000; cpu_register_v0 = 32'hCAFEF00D; push_dn(1'b1, 32'hCAFEF00D, 16);
    do_start(1, 2);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    for (int k = 0; k < 50 && !(cpu_clk_enable && !cpu_reset); k++) @(negedge clk);
    repeat (3) @(negedge clk);
    start = 1'b1; word_count = '0;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Zero-length loads around the completion/timeout boundary.
    for (int i = 0; i < 3; i++) begin
      halt_at = zh[i]; cpu_register_v0 = 32'(zh[i]);
      push_dn(zto[i], 32'(zh[i]), zlen[i]);
      do_start(0, 4);
      wait_done();
    end

    // Asynchronous reset after two bytes of word 1, then a clean reload.
    push_wr(32'hBFC00000, 32'h2484FFF5);
    do_start(2, 2);
    for (int i = 0; i < 6; i++) send_byte(prog[i], 1'b0);
    reset = 1'b0;
    request(1);
    reset = 1'b1;
    push_wr(32'hBFC00000, 32'h2484FFF5);
    push_wr(32'hBFC00004, 32'h2882FFB3);
    halt_at = 4; cpu_register_v0 = 32'hA5A5A5A5; push_dn(1'b0, 32'hA5A5A5A5, 5);
    do_start(2, 2);
    for (int i = 0; i < 8; i++) send_byte(prog[i], 1'b0);
    wait_done();

    // Overflowing count is clamped to the memory capacity of 8 words.
    for (int w = 0; w < 8; w++) push_wr(RV + 32'(4 * w), {8'(8'hA0 + w), 8'h11, 8'h22, 8'(w)});
    halt_at = 2; cpu_register_v0 = 32'h9; push_dn(1'b0, 32'h9, 3);
    do_start(9, 2);
    for (int w = 0; w < 8; w++) begin
      send_byte(8'(8'hA0 + w), 1'b0); send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);         send_byte(8'(w), 1'b0);
    end
    wait_done();

    repeat (4) @(negedge clk);
    request(3);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
